// File: rtl/rgb_pkg.sv
// Shared colour types and channel helpers for the RGB PWM driver.
// RGB_PWM_FADE_EN adds the one-step fade helper used by the fade build.
package rgb_pkg;
  localparam int CH_W = 8;
  typedef logic [3*CH_W-1:0] rgb_t;
  typedef logic [CH_W-1:0] ch_t;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam rgb_t WHITE = 24'hFFFFFF;
`ifdef RGB_PWM_FADE_EN
  function automatic ch_t fade_step(
    input ch_t cur,
    input ch_t tgt
  );
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction
`endif
endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: duty register, compare and output flop.
// RGB_PWM_FADE_EN selects stepped fading instead of direct duty loads.
module pwm_channel
  import rgb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic boundary,
  input  ch_t  target,
  input  ch_t  cnt,
  output ch_t  duty,
  output logic pwm
);
  ch_t  duty_q, duty_d;
  logic pwm_q, pwm_d;

  // next duty and compare result
  always_comb begin
    duty_d = duty_q;
    pwm_d  = enable && (cnt < duty_q);
`ifdef RGB_PWM_FADE_EN
    if (enable && boundary)
      duty_d = fade_step(duty_q, target);
`else
    if (!enable || boundary)
      duty_d = target;
`endif
  end

  // duty and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty = duty_q;
  assign pwm  = pwm_q;
endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver: prescaler, period counter, channels.
// Define RGB_PWM_FADE_EN for the fading duty build.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        enable,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start,
  output logic [23:0] duty
);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;
  ch_t         cnt_q, cnt_d;
  logic        ps_q, ps_d;
  logic        tick, boundary;
  ch_t         duty_r, duty_g, duty_b;

  assign tick     = enable && (pre_q == PRE_MAX);
  assign boundary = tick && (cnt_q == 8'hFF);

  // prescaler, period counter and boundary pulse
  always_comb begin
    pre_d = pre_q + 16'd1;
    cnt_d = cnt_q;
    ps_d  = boundary;
    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 8'd1;
    end
  end

  // timing state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  pwm_channel u_r (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .boundary (boundary),
    .target   (light[R_LSB +: CH_W]),
    .cnt      (cnt_q),
    .duty     (duty_r),
    .pwm      (pwm_r)
  );

  pwm_channel u_g (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .boundary (boundary),
    .target   (light[G_LSB +: CH_W]),
    .cnt      (cnt_q),
    .duty     (duty_g),
    .pwm      (pwm_g)
  );

  pwm_channel u_b (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .boundary (boundary),
    .target   (light[B_LSB +: CH_W]),
    .cnt      (cnt_q),
    .duty     (duty_b),
    .pwm      (pwm_b)
  );

  assign period_start = ps_q;
  assign duty         = {duty_r, duty_g, duty_b};
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver (PRESCALE 1 and 3 instances).
// Fade scenario runs when RGB_PWM_FADE_EN is defined.
module tb_rgb_pwm_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable, enable3;
  logic [23:0] light, light3;
  logic        pwm_r, pwm_g, pwm_b, period_start;
  logic [23:0] duty;
  logic        pwm_r3, pwm_g3, pwm_b3, period_start3;
  logic [23:0] duty3;

  int cmp_n = 0;
  int err_n = 0;

  typedef struct {
    int r;
    int g;
    int b;
    int ps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .light        (light),
    .enable       (enable),
    .pwm_r        (pwm_r),
    .pwm_g        (pwm_g),
    .pwm_b        (pwm_b),
    .period_start (period_start),
    .duty         (duty)
  );

  rgb_pwm_driver #(.PRESCALE(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .light        (light3),
    .enable       (enable3),
    .pwm_r        (pwm_r3),
    .pwm_g        (pwm_g3),
    .pwm_b        (pwm_b3),
    .period_start (period_start3),
    .duty         (duty3)
  );

  task automatic push(input int r, input int g, input int b);
    exp_t e;
    e.r = r;
    e.g = g;
    e.b = b;
    e.ps = 1;
    sb.push_back(e);
  endtask

  task automatic measure(
    input  int          sel,
    input  int          n,
    input  int          chg_at,
    input  logic [23:0] chg,
    output int          cr,
    output int          cg,
    output int          cb,
    output int          cps,
    output logic [23:0] dpre,
    output logic [23:0] dend
  );
    cr = 0; cg = 0; cb = 0; cps = 0;
    dpre = '0; dend = '0;
    for (int i = 1; i <= n; i++) begin
      if (i == chg_at) light = chg;
      @(negedge clk);
      if (sel == 0) begin
        cr += int'(pwm_r);
        cg += int'(pwm_g);
        cb += int'(pwm_b);
        cps += int'(period_start);
        dend = duty;
      end else begin
        cr += int'(pwm_r3);
        cg += int'(pwm_g3);
        cb += int'(pwm_b3);
        cps += int'(period_start3);
        dend = duty3;
      end
      if (i == n - 1) dpre = dend;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    enable = 1'b0;
    enable3 = 1'b0;
    light = 24'h0;
    light3 = 24'h010000;
    repeat (3) @(negedge clk);
    cmp_n += 3;
    if ({pwm_r, pwm_g, pwm_b, period_start} !== 4'b0) begin
      err_n++;
      $display("FAIL reset_out: got %b want 0000",
               {pwm_r, pwm_g, pwm_b, period_start});
    end
    if (duty !== 24'h0) begin
      err_n++;
      $display("FAIL reset_duty: got %h want 000000", duty);
    end
    if ({pwm_r3, period_start3, duty3} !== 26'h0) begin
      err_n++;
      $display("FAIL reset_p3: got %b %b %h want 0 0 000000",
               pwm_r3, period_start3, duty3);
    end
  endtask

  task automatic test_white;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    light = 24'hFFFFFF;
    enable = 1'b1;
    rst = 1'b1;
    push(0, 0, 0);
    push(255, 255, 255);
    push(255, 255, 255);
    for (int w = 0; w < 3; w++) begin
      measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      cmp_n += 4;
      if (cr !== e.r) begin err_n++; $display("FAIL white_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cg !== e.g) begin err_n++; $display("FAIL white_g[%0d]: got %0d want %0d", w, cg, e.g); end
      if (cb !== e.b) begin err_n++; $display("FAIL white_b[%0d]: got %0d want %0d", w, cb, e.b); end
      if (cps !== e.ps) begin err_n++; $display("FAIL white_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
    end
  endtask

  task automatic test_colours;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    light = 24'h408000;
    push(255, 255, 255);
    push(64, 128, 0);
    push(64, 128, 0);
    for (int w = 0; w < 3; w++) begin
      measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      cmp_n += 4;
      if (cr !== e.r) begin err_n++; $display("FAIL col_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cg !== e.g) begin err_n++; $display("FAIL col_g[%0d]: got %0d want %0d", w, cg, e.g); end
      if (cb !== e.b) begin err_n++; $display("FAIL col_b[%0d]: got %0d want %0d", w, cb, e.b); end
      if (cps !== e.ps) begin err_n++; $display("FAIL col_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
    end
  endtask

  task automatic test_midchange;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    light = 24'h100000;
    push(64, 128, 0);
    push(16, 0, 0);
    push(240, 0, 0);
    for (int w = 0; w < 3; w++) begin
      measure(0, 256, (w == 1) ? 50 : -1, 24'hF00000,
              cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      cmp_n += 4;
      if (cr !== e.r) begin err_n++; $display("FAIL mid_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cg !== e.g) begin err_n++; $display("FAIL mid_g[%0d]: got %0d want %0d", w, cg, e.g); end
      if (cb !== e.b) begin err_n++; $display("FAIL mid_b[%0d]: got %0d want %0d", w, cb, e.b); end
      if (cps !== e.ps) begin err_n++; $display("FAIL mid_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
      if (w == 1) begin
        cmp_n += 2;
        if (dp !== 24'h100000) begin err_n++; $display("FAIL mid_duty_pre: got %h want 100000", dp); end
        if (de !== 24'hF00000) begin err_n++; $display("FAIL mid_duty_end: got %h want F00000", de); end
      end
    end
  endtask

  task automatic test_disable;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    light = 24'h808080;
    push(240, 0, 0);
    push(0, 0, 32);
    measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
    e = sb.pop_front();
    cmp_n += 4;
    if (cr !== e.r) begin err_n++; $display("FAIL dis_r[0]: got %0d want %0d", cr, e.r); end
    if (cg !== e.g) begin err_n++; $display("FAIL dis_g[0]: got %0d want %0d", cg, e.g); end
    if (cb !== e.b) begin err_n++; $display("FAIL dis_b[0]: got %0d want %0d", cb, e.b); end
    if (cps !== e.ps) begin err_n++; $display("FAIL dis_ps[0]: got %0d want %0d", cps, e.ps); end
    repeat (101) @(negedge clk);
    cmp_n++;
    if ({pwm_r, pwm_g, pwm_b} !== 3'b111) begin
      err_n++;
      $display("FAIL dis_pre: got %b want 111", {pwm_r, pwm_g, pwm_b});
    end
    enable = 1'b0;
    @(negedge clk);
    cmp_n++;
    if ({pwm_r, pwm_g, pwm_b, period_start} !== 4'b0) begin
      err_n++;
      $display("FAIL dis_off: got %b want 0000",
               {pwm_r, pwm_g, pwm_b, period_start});
    end
    light = 24'h000020;
    @(negedge clk);
    cmp_n++;
    if (duty !== 24'h000020) begin
      err_n++;
      $display("FAIL dis_track: got %h want 000020", duty);
    end
    repeat (3) @(negedge clk);
    enable = 1'b1;
    measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
    e = sb.pop_front();
    cmp_n += 4;
    if (cr !== e.r) begin err_n++; $display("FAIL dis_r[1]: got %0d want %0d", cr, e.r); end
    if (cg !== e.g) begin err_n++; $display("FAIL dis_g[1]: got %0d want %0d", cg, e.g); end
    if (cb !== e.b) begin err_n++; $display("FAIL dis_b[1]: got %0d want %0d", cb, e.b); end
    if (cps !== e.ps) begin err_n++; $display("FAIL dis_ps[1]: got %0d want %0d", cps, e.ps); end
  endtask

  task automatic test_reset_mid;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    light = 24'hFFFFFF;
    push(0, 0, 32);
    push(0, 0, 0);
    push(64, 128, 0);
    measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
    e = sb.pop_front();
    cmp_n += 2;
    if (cb !== e.b) begin err_n++; $display("FAIL rmid_b[0]: got %0d want %0d", cb, e.b); end
    if (cps !== e.ps) begin err_n++; $display("FAIL rmid_ps[0]: got %0d want %0d", cps, e.ps); end
    repeat (40) @(negedge clk);
    cmp_n++;
    if (pwm_r !== 1'b1) begin err_n++; $display("FAIL rmid_pre: got %b want 1", pwm_r); end
    rst = 1'b0;
    @(negedge clk);
    cmp_n++;
    if ({pwm_r, pwm_g, pwm_b, period_start, duty} !== 28'h0) begin
      err_n++;
      $display("FAIL rmid_off: got %b %h want 0000 000000",
               {pwm_r, pwm_g, pwm_b, period_start}, duty);
    end
    light = 24'h408000;
    rst = 1'b1;
    for (int w = 1; w < 3; w++) begin
      measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      cmp_n += 4;
      if (cr !== e.r) begin err_n++; $display("FAIL rmid_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cg !== e.g) begin err_n++; $display("FAIL rmid_g[%0d]: got %0d want %0d", w, cg, e.g); end
      if (cb !== e.b) begin err_n++; $display("FAIL rmid_b[%0d]: got %0d want %0d", w, cb, e.b); end
      if (cps !== e.ps) begin err_n++; $display("FAIL rmid_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
    end
  endtask

  task automatic test_prescale3;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    enable3 = 1'b1;
    push(3, 0, 0);
    push(3, 0, 0);
    for (int w = 0; w < 2; w++) begin
      measure(1, 768, -1, 24'h0, cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      cmp_n += 4;
      if (cr !== e.r) begin err_n++; $display("FAIL p3_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cg !== e.g) begin err_n++; $display("FAIL p3_g[%0d]: got %0d want %0d", w, cg, e.g); end
      if (cb !== e.b) begin err_n++; $display("FAIL p3_b[%0d]: got %0d want %0d", w, cb, e.b); end
      if (cps !== e.ps) begin err_n++; $display("FAIL p3_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
    end
  endtask

  task automatic test_fade;
    int cr, cg, cb, cps;
    logic [23:0] dp, de;
    exp_t e;
    int dexp[$];
    int dgot;
    light = 24'h030000;
    enable = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push((k < 3) ? k : 3, 0, 0);
      dexp.push_back((k < 2) ? k + 1 : 3);
    end
    for (int k = 0; k < 4; k++) begin
      push(3 - k, 0, 0);
      dexp.push_back((k < 3) ? 2 - k : 0);
    end
    for (int w = 0; w < 9; w++) begin
      if (w == 5) light = 24'h0;
      measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
      e = sb.pop_front();
      dgot = int'(de[23:16]);
      cmp_n += 3;
      if (cr !== e.r) begin err_n++; $display("FAIL fade_r[%0d]: got %0d want %0d", w, cr, e.r); end
      if (cps !== e.ps) begin err_n++; $display("FAIL fade_ps[%0d]: got %0d want %0d", w, cps, e.ps); end
      if (dgot !== dexp[w]) begin err_n++; $display("FAIL fade_duty[%0d]: got %0d want %0d", w, dgot, dexp[w]); end
    end
    light = 24'h030000;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    cmp_n++;
    if (duty !== 24'h0) begin err_n++; $display("FAIL fade_hold: got %h want 000000", duty); end
    enable = 1'b1;
    measure(0, 256, -1, 24'h0, cr, cg, cb, cps, dp, de);
    cmp_n += 2;
    if (cr !== 0) begin err_n++; $display("FAIL fade_resume_r: got %0d want 0", cr); end
    if (de !== 24'h010000) begin err_n++; $display("FAIL fade_resume_duty: got %h want 010000", de); end
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_n++;
    if ({pwm_r, pwm_g, pwm_b, period_start, duty} !== 28'h0) begin
      err_n++;
      $display("FAIL fade_rst: got %b %h want 0000 000000",
               {pwm_r, pwm_g, pwm_b, period_start}, duty);
    end
  endtask

  initial begin
    test_reset;
`ifdef RGB_PWM_FADE_EN
    test_fade;
`else
    test_white;
    test_colours;
    test_midchange;
    test_disable;
    test_reset_mid;
    test_prescale3;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
